// File: rtl/flit_depacketizer_if.sv
// Flit-in / word-out bus of the depacketizer: flit stream, framed payload stream and status.
// The slave modport is the depacketizer's view; master is the attached environment.
interface flit_depacketizer_if #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
);
    logic [FLIT_WIDTH-1:0]      in_flit;
    logic                       in_valid;
    logic                       in_ready;
    logic [FLIT_DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_sop;
    logic                       out_eop;
    logic [7:0]                 out_src;
    logic [7:0]                 out_dest;
    logic                       err;
    logic [2:0]                 err_code;
    logic [15:0]                pkt_count;

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop,
        output out_src, out_dest, err, err_code, pkt_count
    );

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop,
        input  out_src, out_dest, err, err_code, pkt_count
    );
endinterface

// File: rtl/flit_depacketizer.sv
// Strips head flits from the incoming flit stream, emits framed payload words,
// flags framing violations against the head length and counts delivered packets.
module flit_depacketizer #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    parameter int MAX_LEN         = 256
) (
    input logic                clk,
    input logic                rst,
    flit_depacketizer_if.slave bus
);
    localparam int CW = $clog2(MAX_LEN) + 1;
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_BODY = 2'b00;
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_HEAD = 2'b01;
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_TAIL = 2'b10;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t                     state;
    logic [CW-1:0]              count;
    logic [CW-1:0]              len_q;
    logic [CW-1:0]              count_next;
    logic [FLIT_TYPE_WIDTH-1:0] ftype;
    logic [FLIT_DATA_WIDTH-1:0] fdata;
    logic [15:0]                hlen;
    logic                       hlen_ok;
    logic                       accept;

    // Outside PAYLOAD a head must wait for the last beat to drain so the
    // packet IDs never change underneath a pending beat.
    always_comb begin
        ftype      = bus.in_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
        fdata      = bus.in_flit[FLIT_DATA_WIDTH-1:0];
        hlen       = fdata[15:0];
        hlen_ok    = (hlen != 16'd0) && (hlen <= 16'(MAX_LEN));
        count_next = count + 1'b1;
        if (state == PAYLOAD)
            bus.in_ready = !bus.out_valid || bus.out_ready;
        else
            bus.in_ready = !bus.out_valid;
        accept = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            len_q         <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_src   <= '0;
            bus.out_dest  <= '0;
            bus.err       <= 1'b0;
            bus.err_code  <= '0;
            bus.pkt_count <= '0;
        end else begin
            bus.err      <= 1'b0;
            bus.err_code <= '0;

            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                if (bus.out_eop)
                    bus.pkt_count <= bus.pkt_count + 16'd1;
            end

            if (accept) begin
                case (ftype)
                    T_HEAD: begin
                        if (hlen_ok) begin
                            bus.out_dest <= fdata[31:24];
                            bus.out_src  <= fdata[23:16];
                            len_q        <= hlen[CW-1:0];
                            count        <= '0;
                            state        <= PAYLOAD;
                        end else begin
                            state <= DROP;
                        end
                        // An abort takes precedence so one head reports one error.
                        if (state == PAYLOAD) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 3'd5;
                        end else if (state == IDLE && !hlen_ok) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 3'd1;
                        end else if (state == DROP && !hlen_ok) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 3'd1;
                        end
                    end
                    T_BODY, T_TAIL: begin
                        case (state)
                            IDLE: begin
                                bus.err      <= 1'b1;
                                bus.err_code <= 3'd2;
                            end
                            DROP: begin
                                if (ftype == T_TAIL)
                                    state <= IDLE;
                            end
                            default: begin
                                if (ftype == T_TAIL || count_next < len_q) begin
                                    bus.out_valid <= 1'b1;
                                    bus.out_data  <= fdata;
                                    bus.out_sop   <= (count == '0);
                                    bus.out_eop   <= (ftype == T_TAIL);
                                    count         <= count_next;
                                    if (ftype == T_TAIL) begin
                                        state <= IDLE;
                                        if (count_next != len_q) begin
                                            bus.err      <= 1'b1;
                                            bus.err_code <= 3'd3;
                                        end
                                    end
                                end else begin
                                    bus.err      <= 1'b1;
                                    bus.err_code <= 3'd4;
                                    state        <= DROP;
                                end
                            end
                        endcase
                    end
                    default: begin
                        if (state != DROP) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 3'd7;
                            if (state == PAYLOAD)
                                state <= DROP;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flit_depacketizer.sv
// Directed self-checking bench for flit_depacketizer: one task per scenario,
// with a negedge monitor recording delivered beats and error pulses.
module tb_flit_depacketizer;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] BAD  = 2'b11;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [7:0]  src;
        logic [7:0]  dest;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    beat_t      beats[$];
    logic [2:0] errs[$];

    flit_depacketizer_if bus();

    flit_depacketizer #(.MAX_LEN(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so negedge sees exactly what the next edge samples.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            beats.push_back('{bus.out_data, bus.out_sop, bus.out_eop, bus.out_src, bus.out_dest, cyc});
        if (!rst && bus.err)
            errs.push_back(bus.err_code);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        errs.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [31:0] d);
        int n = 0;
        bus.in_flit  = {t, d};
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout flit=%h in_ready=%b required 1", {t, d}, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.pkt_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_pkt_count got %0d want 0", bus.pkt_count); end
        checks++;
        if ({bus.err, bus.out_src, bus.out_dest, bus.out_data} !== 49'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs err=%b src=%h dest=%h data=%h want all 0", bus.err, bus.out_src, bus.out_dest, bus.out_data);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ed[3] = '{32'hA, 32'hB, 32'hC};
        clear_mon();
        applyStimulus(HEAD, 32'h1234_0003);
        applyStimulus(BODY, 32'hA);
        applyStimulus(BODY, 32'hB);
        applyStimulus(TAIL, 32'hC);
        idle(4);
        checks++;
        if (beats.size() != 3) begin
            failures++;
            $display("[TB] FAIL basic_beat_count got %0d want 3", beats.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[i].d !== ed[i] || beats[i].sop !== (i == 0) || beats[i].eop !== (i == 2) ||
                    beats[i].src !== 8'h34 || beats[i].dest !== 8'h12) begin
                    failures++;
                    $display("[TB] FAIL basic_beat%0d got d=%h sop=%b eop=%b src=%h dest=%h want d=%h sop=%b eop=%b src=34 dest=12",
                             i, beats[i].d, beats[i].sop, beats[i].eop, beats[i].src, beats[i].dest, ed[i], i == 0, i == 2);
                end
            end
            checks++;
            if (beats[2].cyc - beats[0].cyc != 2) begin
                failures++;
                $display("[TB] FAIL basic_throughput got span %0d cycles want 2", beats[2].cyc - beats[0].cyc);
            end
        end
        checks++;
        if (errs.size() != 0) begin failures++; $display("[TB] FAIL basic_no_err got %0d errors want 0", errs.size()); end
        checks++;
        if (bus.pkt_count !== 16'd1) begin failures++; $display("[TB] FAIL basic_pkt_count got %0d want 1", bus.pkt_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed[3] = '{32'hA, 32'hB, 32'hC};
        clear_mon();
        bus.out_ready = 1'b0;
        fork
            begin
                applyStimulus(HEAD, 32'h1234_0003);
                applyStimulus(BODY, 32'hA);
                applyStimulus(BODY, 32'hB);
                applyStimulus(TAIL, 32'hC);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA || bus.in_ready !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL stall_hold%0d got valid=%b data=%h in_ready=%b want 1 0000000a 0",
                                 i, bus.out_valid, bus.out_data, bus.in_ready);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(4);
        checks++;
        if (beats.size() != 3) begin
            failures++;
            $display("[TB] FAIL stall_beat_count got %0d want 3", beats.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[i].d !== ed[i] || beats[i].sop !== (i == 0) || beats[i].eop !== (i == 2)) begin
                    failures++;
                    $display("[TB] FAIL stall_beat%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                             i, beats[i].d, beats[i].sop, beats[i].eop, ed[i], i == 0, i == 2);
                end
            end
        end
        checks++;
        if (bus.pkt_count !== 16'd2) begin failures++; $display("[TB] FAIL stall_pkt_count got %0d want 2", bus.pkt_count); end
    endtask

    task automatic test_short_packet();
        clear_mon();
        applyStimulus(HEAD, 32'h2143_0003);
        applyStimulus(BODY, 32'h100);
        applyStimulus(TAIL, 32'h101);
        applyStimulus(HEAD, 32'h0102_0001);
        applyStimulus(TAIL, 32'h200);
        idle(4);
        checks++;
        if (beats.size() != 3) begin
            failures++;
            $display("[TB] FAIL short_beat_count got %0d want 3", beats.size());
        end else begin
            checks++;
            if (beats[1].d !== 32'h101 || beats[1].eop !== 1'b1 || beats[1].src !== 8'h43 || beats[1].dest !== 8'h21) begin
                failures++;
                $display("[TB] FAIL short_eop_beat got d=%h eop=%b src=%h dest=%h want 00000101 1 43 21",
                         beats[1].d, beats[1].eop, beats[1].src, beats[1].dest);
            end
            checks++;
            if (beats[2].d !== 32'h200 || beats[2].sop !== 1'b1 || beats[2].eop !== 1'b1 ||
                beats[2].src !== 8'h02 || beats[2].dest !== 8'h01) begin
                failures++;
                $display("[TB] FAIL short_next_pkt got d=%h sop=%b eop=%b src=%h dest=%h want 00000200 1 1 02 01",
                         beats[2].d, beats[2].sop, beats[2].eop, beats[2].src, beats[2].dest);
            end
        end
        checks++;
        if (errs.size() != 1 || errs[0] !== 3'd3) begin
            failures++;
            $display("[TB] FAIL short_err got count=%0d first=%0d want count=1 code=3", errs.size(), errs.size() ? errs[0] : 3'd0);
        end
        checks++;
        if (bus.pkt_count !== 16'd4) begin failures++; $display("[TB] FAIL short_pkt_count got %0d want 4", bus.pkt_count); end
    endtask

    task automatic test_missing_tail();
        clear_mon();
        applyStimulus(HEAD, 32'h5566_0001);
        applyStimulus(BODY, 32'h1);
        applyStimulus(BODY, 32'h2);
        applyStimulus(TAIL, 32'h3);
        applyStimulus(HEAD, 32'h7788_0001);
        applyStimulus(TAIL, 32'h55);
        idle(4);
        checks++;
        if (beats.size() != 1) begin
            failures++;
            $display("[TB] FAIL missing_tail_beat_count got %0d want 1", beats.size());
        end else begin
            checks++;
            if (beats[0].d !== 32'h55 || beats[0].sop !== 1'b1 || beats[0].eop !== 1'b1 ||
                beats[0].src !== 8'h88 || beats[0].dest !== 8'h77) begin
                failures++;
                $display("[TB] FAIL missing_tail_beat got d=%h sop=%b eop=%b src=%h dest=%h want 00000055 1 1 88 77",
                         beats[0].d, beats[0].sop, beats[0].eop, beats[0].src, beats[0].dest);
            end
        end
        checks++;
        if (errs.size() != 1 || errs[0] !== 3'd4) begin
            failures++;
            $display("[TB] FAIL missing_tail_err got count=%0d first=%0d want count=1 code=4", errs.size(), errs.size() ? errs[0] : 3'd0);
        end
        checks++;
        if (bus.pkt_count !== 16'd5) begin failures++; $display("[TB] FAIL missing_tail_pkt_count got %0d want 5", bus.pkt_count); end
    endtask

    task automatic test_errors();
        logic [2:0] ee[5] = '{3'd7, 3'd2, 3'd1, 3'd1, 3'd5};
        clear_mon();
        applyStimulus(BAD,  32'hDEAD);
        applyStimulus(BODY, 32'h9);
        applyStimulus(HEAD, 32'h0000_0000);
        applyStimulus(TAIL, 32'h8);
        applyStimulus(HEAD, 32'h0000_0101);
        applyStimulus(BODY, 32'h7);
        applyStimulus(TAIL, 32'h6);
        applyStimulus(HEAD, 32'h0A0B_0002);
        applyStimulus(BODY, 32'h31);
        applyStimulus(HEAD, 32'h0C0D_0001);
        applyStimulus(TAIL, 32'h32);
        idle(4);
        checks++;
        if (errs.size() != 5) begin
            failures++;
            $display("[TB] FAIL errors_count got %0d want 5", errs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (errs[i] !== ee[i]) begin
                    failures++;
                    $display("[TB] FAIL errors_code%0d got %0d want %0d", i, errs[i], ee[i]);
                end
            end
        end
        checks++;
        if (beats.size() != 2) begin
            failures++;
            $display("[TB] FAIL errors_beat_count got %0d want 2", beats.size());
        end else begin
            checks++;
            if (beats[0].d !== 32'h31 || beats[0].sop !== 1'b1 || beats[0].eop !== 1'b0 || beats[0].src !== 8'h0B) begin
                failures++;
                $display("[TB] FAIL errors_aborted_beat got d=%h sop=%b eop=%b src=%h want 00000031 1 0 0b",
                         beats[0].d, beats[0].sop, beats[0].eop, beats[0].src);
            end
            checks++;
            if (beats[1].d !== 32'h32 || beats[1].sop !== 1'b1 || beats[1].eop !== 1'b1 ||
                beats[1].src !== 8'h0D || beats[1].dest !== 8'h0C) begin
                failures++;
                $display("[TB] FAIL errors_after_abort got d=%h sop=%b eop=%b src=%h dest=%h want 00000032 1 1 0d 0c",
                         beats[1].d, beats[1].sop, beats[1].eop, beats[1].src, beats[1].dest);
            end
        end
        checks++;
        if (bus.pkt_count !== 16'd6) begin failures++; $display("[TB] FAIL errors_pkt_count got %0d want 6", bus.pkt_count); end
    endtask

    task automatic test_max_len();
        int bad = 0;
        clear_mon();
        applyStimulus(HEAD, 32'h5AA5_0100);
        for (int i = 0; i < 255; i++)
            applyStimulus(BODY, 32'h1000 + i);
        applyStimulus(TAIL, 32'h1000 + 255);
        idle(4);
        checks++;
        if (beats.size() != 256) begin
            failures++;
            $display("[TB] FAIL maxlen_beat_count got %0d want 256", beats.size());
        end else begin
            for (int i = 0; i < 256; i++)
                if (beats[i].d !== 32'h1000 + i || beats[i].sop !== (i == 0) || beats[i].eop !== (i == 255))
                    bad++;
            checks++;
            if (bad != 0) begin failures++; $display("[TB] FAIL maxlen_beats got %0d wrong beats want 0", bad); end
        end
        checks++;
        if (errs.size() != 0) begin failures++; $display("[TB] FAIL maxlen_no_err got %0d errors want 0", errs.size()); end
        checks++;
        if (bus.pkt_count !== 16'd7) begin failures++; $display("[TB] FAIL maxlen_pkt_count got %0d want 7", bus.pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        clear_mon();
        bus.out_ready = 1'b0;
        applyStimulus(HEAD, 32'hE1E2_0003);
        applyStimulus(BODY, 32'h70);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pending got valid=%b want 1", bus.out_valid); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pkt_count !== 16'd0 || bus.in_ready !== 1'b1 || bus.out_src !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rstmid_state got valid=%b pkt_count=%0d in_ready=%b src=%h want 0 0 1 00",
                     bus.out_valid, bus.pkt_count, bus.in_ready, bus.out_src);
        end
        bus.out_ready = 1'b1;
        clear_mon();
        applyStimulus(HEAD, 32'hF1F2_0001);
        applyStimulus(TAIL, 32'h99);
        idle(4);
        checks++;
        if (beats.size() != 1 || beats[0].d !== 32'h99 || beats[0].sop !== 1'b1 || beats[0].eop !== 1'b1 ||
            beats[0].src !== 8'hF2 || beats[0].dest !== 8'hF1) begin
            failures++;
            $display("[TB] FAIL rstmid_new_pkt got count=%0d d=%h want count=1 d=00000099 sop=eop=1 src=f2 dest=f1",
                     beats.size(), beats.size() ? beats[0].d : 32'h0);
        end
        checks++;
        if (errs.size() != 0 || bus.pkt_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL rstmid_status got errors=%0d pkt_count=%0d want 0 1", errs.size(), bus.pkt_count);
        end
    endtask

    initial begin
        bus.in_flit   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_short_packet();
        test_missing_tail();
        test_errors();
        test_max_len();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
